// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the 7-segment display scanners.
//   SEG_BLANK  : digit code that the decoder renders as all segments off
//   MAX_DIGITS : widest display bank supported
//   onehot_n() : active-low one-hot anode pattern for a display index
package seg_pkg;

  localparam logic [3:0] SEG_BLANK  = 4'hF;
  localparam int         MAX_DIGITS = 8;

  function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [2:0] idx);
    onehot_n = ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Bundle between the classifier/host side and the display scanner.
//   iValid/iDigit/iClear : result stream and history clear, into the scanner
//   oDigit/oAn/oCount    : decoder code, active-low anodes, stored result count
// slave  : the scanner; master : whoever feeds results and watches outputs.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                  iValid;
  logic [3:0]            iDigit;
  logic                  iClear;
  logic [3:0]            oDigit;
  logic [NUM_DIGITS-1:0] oAn;
  logic [3:0]            oCount;

  modport master (output iValid, iDigit, iClear, input oDigit, oAn, oCount);
  modport slave  (input iValid, iDigit, iClear, output oDigit, oAn, oCount);
endinterface

// File: rtl/seg_scan_driver_refresh_tick.sv
// Free-running slot counter for display scanners.
//   clk, rst : clock and asynchronous active-high reset
//   cnt      : 0..DIV-1, wraps to 0
//   wrap     : high during the cycle cnt == DIV-1 (the edge that wraps it)
module refresh_tick #(
  parameter int DIV = 100000,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Result history and time-multiplexed scanner for a 7-segment display bank.
//   iClk, iRst : clock and asynchronous active-high reset
//   bus.iValid : one-cycle pulse, bus.iDigit holds a new result (0..9)
//   bus.iClear : synchronous history clear (applied before a same-edge write)
//   bus.oDigit : code of the displayed slot, to the decoder (registered)
//   bus.oAn    : active-low anode select, at most one bit low (registered)
//   bus.oCount : number of stored results, saturating at NUM_DIGITS
// Newest result is hist[0], shown on the rightmost display (anode bit 0).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               iClk,
  input  logic               iRst,
  seg_scan_driver_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0]                cnt;
  logic                         wrap;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   hist_q, hist_d, hist_base;
  logic [3:0]                   count_q, count_d, count_base;
  logic [3:0]                   digit_q, digit_d, digit_in;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic [MAX_DIGITS-1:0]        an_full;

  refresh_tick #(.DIV(REFRESH_DIV)) u_tick (
    .clk  (iClk),
    .rst  (iRst),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Display index steps only when the slot counter wraps.
  always_comb begin
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // Clear is folded in before the shift so a same-edge write lands on a
  // blank history with a count of one.
  always_comb begin
    digit_in   = (bus.iDigit > 4'd9) ? SEG_BLANK : bus.iDigit;
    hist_base  = bus.iClear ? '1 : hist_q;
    count_base = bus.iClear ? '0 : count_q;
    hist_d     = hist_base;
    count_d    = count_base;
    if (bus.iValid) begin
      hist_d  = {hist_base[NUM_DIGITS-2:0], digit_in};
      count_d = (count_base == 4'(NUM_DIGITS)) ? count_base : count_base + 4'd1;
    end
  end

  // Outputs are derived from this cycle's (cnt, idx) and registered together,
  // so anode and code change on the same edge.
  always_comb begin
    an_full = onehot_n(3'(idx_q));
    an_d    = '1;
    digit_d = SEG_BLANK;
    if (32'(cnt) >= 32'(BLANK_CYCLES)) begin
      an_d    = an_full[NUM_DIGITS-1:0];
      digit_d = hist_q[idx_q];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx_q   <= '0;
      hist_q  <= '1;
      count_q <= '0;
      digit_q <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      count_q <= count_d;
      digit_q <= digit_d;
      an_q    <= an_d;
    end
  end

  assign bus.oDigit = digit_q;
  assign bus.oAn    = an_q;
  assign bus.oCount = count_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int BLK = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (DIV),
    .BLANK_CYCLES(BLK)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edges since reset give the scan phase directly; history is a queue
  // with the newest result at the front.
  int         edges;
  int         q[$];
  logic [3:0] exp_an, exp_dig, exp_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges   <= 0;
      q.delete();
      exp_an  <= 4'hF;
      exp_dig <= 4'hF;
      exp_cnt <= 4'd0;
    end else begin
      if ((edges % DIV) < BLK) begin
        exp_an  <= 4'hF;
        exp_dig <= 4'hF;
      end else begin
        exp_an  <= ~(4'b0001 << ((edges % (DIV * ND)) / DIV));
        exp_dig <= (((edges % (DIV * ND)) / DIV) < q.size()) ?
                   4'(q[(edges % (DIV * ND)) / DIV]) : 4'hF;
      end
      edges <= edges + 1;
      if (bus.iClear) q.delete();
      if (bus.iValid) begin
        q.push_front((bus.iDigit > 4'd9) ? 15 : int'(bus.iDigit));
        if (q.size() > ND) void'(q.pop_back());
      end
      exp_cnt <= 4'(q.size());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("an",    {4'h0, bus.oAn},    {4'h0, exp_an});
      check("digit", {4'h0, bus.oDigit}, {4'h0, exp_dig});
      check("count", {4'h0, bus.oCount}, {4'h0, exp_cnt});
    end
  end

  // Starts and ends on a negedge.
  task automatic pulse(input logic [3:0] d, input logic clr, input logic vld);
    bus.iValid = vld;
    bus.iDigit = d;
    bus.iClear = clr;
    @(negedge clk);
    bus.iValid = 1'b0;
    bus.iClear = 1'b0;
  endtask

  task automatic wait_an(input string name, input logic [3:0] an, input logic [3:0] dig);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.oAn == an) found = 1'b1;
    end
    check({name, "_seen"}, {7'd0, found}, 8'd1);
    if (found) check(name, {4'h0, bus.oDigit}, {4'h0, dig});
  endtask

  logic [3:0] an_tbl [16];

  initial begin
    an_tbl = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
               4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    bus.iValid = 1'b0;
    bus.iDigit = 4'h0;
    bus.iClear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an",    {4'h0, bus.oAn},    8'h0F);
    check("rst_digit", {4'h0, bus.oDigit}, 8'h0F);
    check("rst_count", {4'h0, bus.oCount}, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("seq_an%0d", i), {4'h0, bus.oAn}, {4'h0, an_tbl[i]});
    end
    @(negedge clk);

    pulse(4'd3, 1'b0, 1'b1);
    pulse(4'd7, 1'b0, 1'b1);
    pulse(4'd1, 1'b0, 1'b1);
    check("model_size", 8'(q.size()), 8'd3);
    check("model_q0", 8'(q[0]), 8'd1);
    check("model_q2", 8'(q[2]), 8'd3);
    check("cnt3", {4'h0, bus.oCount}, 8'd3);
    wait_an("s0_1", 4'hE, 4'd1);
    wait_an("s1_7", 4'hD, 4'd7);
    wait_an("s2_3", 4'hB, 4'd3);
    wait_an("s3_F", 4'h7, 4'hF);

    for (int d = 0; d < 6; d++) pulse(4'(d), 1'b0, 1'b1);
    check("cnt_sat", {4'h0, bus.oCount}, 8'd4);
    wait_an("ov_s0", 4'hE, 4'd5);
    wait_an("ov_s3", 4'h7, 4'd2);

    pulse(4'd9, 1'b1, 1'b1);
    check("clrwr_cnt", {4'h0, bus.oCount}, 8'd1);
    wait_an("clrwr_s0", 4'hE, 4'd9);
    wait_an("clrwr_s1", 4'hD, 4'hF);

    pulse(4'hB, 1'b0, 1'b1);
    check("hex_cnt", {4'h0, bus.oCount}, 8'd2);
    wait_an("hex_s0", 4'hE, 4'hF);
    wait_an("hex_s1", 4'hD, 4'd9);

    pulse(4'd0, 1'b1, 1'b0);
    check("clr_cnt", {4'h0, bus.oCount}, 8'd0);
    wait_an("clr_s1", 4'hD, 4'hF);

    pulse(4'd5, 1'b0, 1'b1);
    wait_an("pre_rst", 4'hE, 4'd5);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_an",    {4'h0, bus.oAn},    8'h0F);
    check("mid_rst_digit", {4'h0, bus.oDigit}, 8'h0F);
    check("mid_rst_count", {4'h0, bus.oCount}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_an("post_rst_s0", 4'hE, 4'hF);
    wait_an("post_rst_s3", 4'h7, 4'hF);

    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
